// File: rtl/dac_seq_ctrl.sv
// Queued DAC sequencer: buffers wordline bitmaps, issues each one with valid/ready,
// waits a programmable settle latency, then pulses done. Supports timeout, overflow and abort.
package snn_soc_pkg;
    localparam int NUM_INPUTS = 16;
endpackage

module dac_seq_ctrl #(
    parameter  int NUM_INPUTS = snn_soc_pkg::NUM_INPUTS,
    parameter  int FIFO_DEPTH = 4,
    parameter  int LAT_W      = 8,
    parameter  int TO_W       = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1),
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] wl_bitmap,
    input  logic                  wl_valid_pulse,
    input  logic [LAT_W-1:0]      cfg_latency,
    input  logic [TO_W-1:0]       cfg_timeout,
    input  logic                  abort,
    input  logic                  clr_overflow,
    output logic [NUM_INPUTS-1:0] wl_spike,
    output logic                  dac_valid,
    input  logic                  dac_ready,
    output logic                  dac_done_pulse,
    output logic                  dac_timeout_pulse,
    output logic                  busy,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow_sticky
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LAT} state_e;

    state_e                r_state, w_state_nxt;
    logic                  r_dac_valid, w_dac_valid_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_timeout, w_timeout_nxt;
    logic [LAT_W-1:0]      r_lat_cnt, w_lat_cnt_nxt;
    logic [TO_W-1:0]       r_to_cnt, w_to_cnt_nxt;
    logic                  w_pop, w_push, w_full;

    logic [NUM_INPUTS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [NUM_INPUTS-1:0] r_spike;
    logic                  r_ovf;

    // Fullness uses the registered level only; a same-cycle pop earns no credit.
    assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_push = wl_valid_pulse && !abort && !w_full;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_state_nxt     = r_state;
        w_dac_valid_nxt = r_dac_valid;
        w_done_nxt      = 1'b0;
        w_timeout_nxt   = 1'b0;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        w_pop           = 1'b0;
        if (abort) begin
            w_state_nxt     = S_IDLE;
            w_dac_valid_nxt = 1'b0;
            w_lat_cnt_nxt   = '0;
            w_to_cnt_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_level != '0) begin
                        w_pop           = 1'b1;
                        w_dac_valid_nxt = 1'b1;
                        w_to_cnt_nxt    = '0;
                        w_state_nxt     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A handshake wins over a timeout that expires in the same cycle.
                    if (dac_ready) begin
                        w_dac_valid_nxt = 1'b0;
                        w_lat_cnt_nxt   = cfg_latency;
                        w_to_cnt_nxt    = '0;
                        w_state_nxt     = S_LAT;
                    end else if ((cfg_timeout != '0) && (r_to_cnt == cfg_timeout - TO_W'(1))) begin
                        w_dac_valid_nxt = 1'b0;
                        w_timeout_nxt   = 1'b1;
                        w_to_cnt_nxt    = '0;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    end
                end
                S_LAT: begin
                    if (r_lat_cnt == '0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dac_valid <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_lat_cnt   <= '0;
            r_to_cnt    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_spike     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_state     <= w_state_nxt;
            r_dac_valid <= w_dac_valid_nxt;
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            if (w_pop) begin
                r_spike <= r_mem[r_rd_ptr];
            end
            if (abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
            end
            if (wl_valid_pulse && !abort && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_overflow) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // NOTE: queue storage has no reset; the level and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wl_bitmap;
        end
    end

    assign wl_spike          = r_spike;
    assign dac_valid         = r_dac_valid;
    assign dac_done_pulse    = r_done;
    assign dac_timeout_pulse = r_timeout;
    assign fifo_level        = r_level;
    assign overflow_sticky   = r_ovf;
    assign busy              = (r_state != S_IDLE) || (r_level != '0);

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Bench for dac_seq_ctrl: fixed vector table, directed corner sequences and a
// randomized run, all checked against a timestamp-based transaction model.
module tb_dac_seq_ctrl;

    localparam int NI = 16;
    localparam int D  = 4;

    logic          clk;
    logic          rst_n;
    logic [NI-1:0] wl_bitmap;
    logic          wl_valid_pulse;
    logic [7:0]    cfg_latency;
    logic [15:0]   cfg_timeout;
    logic          abort;
    logic          clr_overflow;
    logic [NI-1:0] wl_spike;
    logic          dac_valid;
    logic          dac_ready;
    logic          dac_done_pulse;
    logic          dac_timeout_pulse;
    logic          busy;
    logic [2:0]    fifo_level;
    logic          overflow_sticky;

    dac_seq_ctrl #(.NUM_INPUTS(NI), .FIFO_DEPTH(D), .LAT_W(8), .TO_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wl_bitmap(wl_bitmap), .wl_valid_pulse(wl_valid_pulse),
        .cfg_latency(cfg_latency), .cfg_timeout(cfg_timeout), .abort(abort),
        .clr_overflow(clr_overflow), .wl_spike(wl_spike), .dac_valid(dac_valid),
        .dac_ready(dac_ready), .dac_done_pulse(dac_done_pulse),
        .dac_timeout_pulse(dac_timeout_pulse), .busy(busy), .fifo_level(fifo_level),
        .overflow_sticky(overflow_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transaction model: a queue of bitmaps plus absolute edge timestamps for
    // the current request (issue edge) and its settle deadline (done edge).
    logic [NI-1:0] mq[$];
    bit            m_valid, m_done, m_to, m_ovf;
    logic [NI-1:0] m_spike;
    int            m_issue, m_done_at, m_edge;

    task automatic model_reset();
        mq.delete();
        m_valid = 0; m_done = 0; m_to = 0; m_ovf = 0;
        m_spike = '0; m_issue = 0; m_done_at = -1; m_edge = 0;
    endtask

    task automatic model_edge();
        int pre_level;
        pre_level = mq.size();
        m_edge++;
        m_done = 0;
        m_to   = 0;
        if (abort) begin
            mq.delete();
            m_valid   = 0;
            m_done_at = -1;
        end else if (m_valid) begin
            if (dac_ready) begin
                m_valid   = 0;
                m_done_at = m_edge + int'(cfg_latency) + 1;
            end else if (cfg_timeout != 0 && (m_edge - m_issue) == int'(cfg_timeout)) begin
                m_valid = 0;
                m_to    = 1;
            end
        end else if (m_done_at >= 0) begin
            if (m_edge == m_done_at) begin
                m_done    = 1;
                m_done_at = -1;
            end
        end else if (pre_level != 0) begin
            m_spike = mq.pop_front();
            m_valid = 1;
            m_issue = m_edge;
        end
        if (!abort && wl_valid_pulse && pre_level < D) mq.push_back(wl_bitmap);
        if (!abort && wl_valid_pulse && pre_level >= D) m_ovf = 1;
        else if (clr_overflow) m_ovf = 0;
    endtask

    task automatic compare_all();
        bit m_busy;
        m_busy = m_valid || (m_done_at >= 0) || (mq.size() != 0);
        check("valid",    dac_valid,         m_valid);
        check("spike",    wl_spike,          m_spike);
        check("done",     dac_done_pulse,    m_done);
        check("timeout",  dac_timeout_pulse, m_to);
        check("busy",     busy,              m_busy);
        check("level",    fifo_level,        mq.size());
        check("overflow", overflow_sticky,   m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        wl_bitmap = '0; wl_valid_pulse = 0; abort = 0; clr_overflow = 0; dac_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", dac_valid, 0);
        check("rst_spike", wl_spike, 0);
        check("rst_done", dac_done_pulse, 0);
        check("rst_timeout", dac_timeout_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow_sticky, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic          pulse;
        logic [NI-1:0] bitmap;
        logic          ready;
        logic          exp_valid;
        logic          exp_done;
        logic          exp_busy;
        logic [2:0]    exp_level;
        logic [NI-1:0] exp_spike;
    } vec_t;

    vec_t          t1 [8];
    logic [NI-1:0] bm [4];
    int            n, dones;
    bit            seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0;
        cfg_latency = 0;
        cfg_timeout = 0;
        clear_inputs();
        t1[0] = '{1, 16'hA5A5, 1, 0, 0, 1, 1, 16'h0000};
        t1[1] = '{0, 16'h0000, 1, 1, 0, 1, 0, 16'hA5A5};
        t1[2] = '{0, 16'h0000, 1, 0, 0, 1, 0, 16'hA5A5};
        t1[3] = '{0, 16'h0000, 1, 0, 0, 1, 0, 16'hA5A5};
        t1[4] = '{0, 16'h0000, 1, 0, 0, 1, 0, 16'hA5A5};
        t1[5] = '{0, 16'h0000, 1, 0, 0, 1, 0, 16'hA5A5};
        t1[6] = '{0, 16'h0000, 1, 0, 1, 0, 0, 16'hA5A5};
        t1[7] = '{0, 16'h0000, 1, 0, 0, 0, 0, 16'hA5A5};

        // T1: single entry, latency 3, ready tied high
        do_reset();
        cfg_latency = 3;
        for (int i = 0; i < 8; i++) begin
            wl_valid_pulse = t1[i].pulse;
            wl_bitmap      = t1[i].bitmap;
            dac_ready      = t1[i].ready;
            step();
            check($sformatf("t1_valid[%0d]", i), dac_valid, t1[i].exp_valid);
            check($sformatf("t1_done[%0d]", i), dac_done_pulse, t1[i].exp_done);
            check($sformatf("t1_busy[%0d]", i), busy, t1[i].exp_busy);
            check($sformatf("t1_level[%0d]", i), fifo_level, t1[i].exp_level);
            check($sformatf("t1_spike[%0d]", i), wl_spike, t1[i].exp_spike);
        end

        // T2: four back-to-back entries, latency 0, issued in FIFO order
        do_reset();
        cfg_latency = 0;
        dac_ready   = 1;
        for (int k = 0; k < 4; k++) bm[k] = 16'($urandom);
        dones = 0;
        for (int c = 0; c < 60 && dones < 4; c++) begin
            wl_valid_pulse = (c < 4);
            wl_bitmap      = (c < 4) ? bm[c] : '0;
            step();
            if (dac_done_pulse) begin
                check($sformatf("t2_order[%0d]", dones), wl_spike, bm[dones]);
                dones++;
            end
        end
        check("t2_done_count", dones, 4);

        // T3: overflow sticky, clear, and set winning over clear
        do_reset();
        for (int k = 0; k < 6; k++) begin
            wl_valid_pulse = 1;
            wl_bitmap      = 16'(k + 1);
            step();
        end
        check("t3_level_full", fifo_level, 4);
        check("t3_ovf_set", overflow_sticky, 1);
        wl_valid_pulse = 0;
        clr_overflow   = 1;
        step();
        check("t3_ovf_clr", overflow_sticky, 0);
        wl_valid_pulse = 1;
        step();
        check("t3_ovf_set_wins", overflow_sticky, 1);
        wl_valid_pulse = 0;
        clr_overflow   = 0;

        // T4: timeout after 10 WAIT cycles, then ready in the 10th cycle wins
        do_reset();
        cfg_timeout = 10;
        cfg_latency = 2;
        wl_valid_pulse = 1;
        wl_bitmap = 16'h0F0F; step();
        wl_bitmap = 16'hF0F0; step();
        wl_valid_pulse = 0;
        n = 0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            n++;
            if (dac_timeout_pulse) seen = 1;
        end
        check("t4_timeout_seen", seen, 1);
        check("t4_timeout_cycles", n, 10);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (dac_valid) seen = 1;
            else step();
        end
        check("t4_next_issued", seen, 1);
        check("t4_next_spike", wl_spike, 16'hF0F0);
        repeat (9) step();
        dac_ready = 1;
        step();
        dac_ready = 0;
        check("t4_ready_wins_valid", dac_valid, 0);
        check("t4_ready_wins_timeout", dac_timeout_pulse, 0);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (dac_done_pulse) seen = 1;
        end
        check("t4_done_after_hs", seen, 1);
        cfg_timeout = 0;

        // T5: abort mid-settle with two entries queued
        do_reset();
        cfg_latency = 20;
        wl_valid_pulse = 1;
        wl_bitmap = 16'h1111; step();
        wl_bitmap = 16'h2222; step();
        wl_bitmap = 16'h3333; step();
        wl_valid_pulse = 0;
        dac_ready = 1; step();
        dac_ready = 0;
        repeat (2) step();
        check("t5_level_before", fifo_level, 2);
        abort = 1;
        wl_valid_pulse = 1;
        wl_bitmap = 16'h4444;
        step();
        abort = 0;
        wl_valid_pulse = 0;
        check("t5_level", fifo_level, 0);
        check("t5_busy", busy, 0);
        check("t5_valid", dac_valid, 0);
        check("t5_spike_kept", wl_spike, 16'h1111);
        check("t5_no_ovf", overflow_sticky, 0);
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (dac_done_pulse) dones++;
        end
        check("t5_no_done", dones, 0);

        // T6: asynchronous reset while waiting for ready
        do_reset();
        wl_valid_pulse = 1;
        wl_bitmap = 16'hBEEF; step();
        wl_valid_pulse = 0;
        step();
        check("t6_in_wait", dac_valid, 1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("t6_valid", dac_valid, 0);
        check("t6_spike", wl_spike, 0);
        check("t6_busy", busy, 0);
        check("t6_level", fifo_level, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) step();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                cfg_latency = 8'($urandom_range(0, 5));
                case ($urandom_range(0, 2))
                    0:       cfg_timeout = 16'd0;
                    1:       cfg_timeout = 16'd3;
                    default: cfg_timeout = 16'd7;
                endcase
            end
            wl_valid_pulse = ($urandom_range(0, 99) < 40);
            wl_bitmap      = 16'($urandom);
            dac_ready      = ($urandom_range(0, 99) < 30);
            abort          = ($urandom_range(0, 99) < 2);
            clr_overflow   = ($urandom_range(0, 99) < 5);
            step();
        end
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
